// File: rtl/dc_svc.sv
// Service-request controller: synchronizes async interrupt/status inputs, builds the
// priority-masked service word, hands it to the CPU and pulses the matching acknowledge.
module dc_svc #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYC    = 2
) (
    input  logic        pin_clk,
    input  logic        pin_rst,
    input  logic [3:0]  irq_in,
    input  logic        evnt_in,
    input  logic        halt_in,
    input  logic        aclo_n,
    input  logic        dclo_n,
    input  logic [2:0]  err_n,
    input  logic        bto,
    input  logic [2:0]  pri,
    input  logic        svc_rd,
    output logic [15:0] svc_word,
    output logic        svc_req,
    output logic [3:0]  irq_ack,
    output logic        evnt_ack
);

    typedef enum logic [1:0] {StIdle, StPend, StAck, StHold} state_e;

    // Bundle layout: {irq[3:0], evnt, halt, aclo_n, dclo_n, err_n[2:0]}
    localparam int unsigned SyncW = 11;
    localparam logic [SyncW-1:0] SyncRst = 11'b0000_0_0_1_0_111;

    logic [SYNC_STAGES*SyncW-1:0] sync_q;
    logic [SyncW-1:0]             sync_out;
    logic [3:0]                   irq_s;
    logic                         evnt_s, halt_s, aclo_s, dclo_s;
    logic [2:0]                   err_s;

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            sync_q <= {SYNC_STAGES{SyncRst}};
        end else begin
            sync_q <= {sync_q[(SYNC_STAGES-1)*SyncW-1:0],
                       irq_in, evnt_in, halt_in, aclo_n, dclo_n, err_n};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES*SyncW-1 -: SyncW];
    assign irq_s    = sync_out[10:7];
    assign evnt_s   = sync_out[6];
    assign halt_s   = sync_out[5];
    assign aclo_s   = sync_out[4];
    assign dclo_s   = sync_out[3];
    assign err_s    = sync_out[2:0];

    state_e      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        evnt_prev_q, aclo_prev_q;
    logic        evnt_p_q, evnt_p_d;
    logic        aclo_p_q, aclo_p_d;
    logic        bto_p_q, bto_p_d;
    logic [15:0] live_word;
    logic        req_cond;
    logic        rd_hit;

    assign live_word = {3'b000,
                        evnt_p_q & (pri < 3'd6),
                        irq_s[0] & (pri < 3'd4),
                        irq_s[1] & (pri < 3'd5),
                        irq_s[2] & (pri < 3'd6),
                        irq_s[3] & (pri < 3'd7),
                        ~aclo_p_q,
                        1'b0,
                        halt_s,
                        err_s,
                        bto_p_q,
                        dclo_s};

    assign req_cond = (|live_word[12:8]) | aclo_p_q | halt_s | bto_p_q | ~(&err_s);

    // A read only clears the latched events that the frozen word actually reported.
    assign rd_hit   = (state_q == StPend) & svc_rd;
    assign evnt_p_d = (evnt_s & ~evnt_prev_q) | (evnt_p_q & ~evnt_ack);
    assign aclo_p_d = (~aclo_s & aclo_prev_q) | (aclo_p_q & ~(rd_hit & ~word_q[7]));
    assign bto_p_d  = bto | (bto_p_q & ~(rd_hit & word_q[1]));

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        svc_word = word_q;
        svc_req  = 1'b0;
        irq_ack  = 4'b0000;
        evnt_ack = 1'b0;
        case (state_q)
            StIdle: begin
                svc_word = live_word;
                if (req_cond) begin
                    word_d  = live_word;
                    state_d = StPend;
                end
            end
            StPend: begin
                svc_req = 1'b1;
                if (svc_rd) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (word_q[8]) begin
                    irq_ack[3] = 1'b1;
                end else if (word_q[9]) begin
                    irq_ack[2] = 1'b1;
                end else if (word_q[10]) begin
                    irq_ack[1] = 1'b1;
                end else if (word_q[11]) begin
                    irq_ack[0] = 1'b1;
                end else if (word_q[12]) begin
                    evnt_ack = 1'b1;
                end
                cnt_d   = 3'(HOLD_CYC);
                state_d = StHold;
            end
            StHold: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end
                if (cnt_q <= 3'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            state_q     <= StIdle;
            word_q      <= 16'h0000;
            cnt_q       <= 3'd0;
            evnt_prev_q <= 1'b0;
            aclo_prev_q <= 1'b1;
            evnt_p_q    <= 1'b0;
            aclo_p_q    <= 1'b0;
            bto_p_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            evnt_prev_q <= evnt_s;
            aclo_prev_q <= aclo_s;
            evnt_p_q    <= evnt_p_d;
            aclo_p_q    <= aclo_p_d;
            bto_p_q     <= bto_p_d;
        end
    end

endmodule

// File: tb/tb_dc_svc.sv
// Bench for dc_svc: directed scenarios followed by randomized transactions scored
// against a word/acknowledge model built from the priority rules.
module tb_dc_svc;

    localparam int unsigned SYNC = 2;
    localparam int unsigned HOLD = 2;

    logic        pin_clk = 1'b0;
    logic        pin_rst;
    logic [3:0]  irq_in;
    logic        evnt_in, halt_in, aclo_n, dclo_n, bto, svc_rd;
    logic [2:0]  err_n, pri;
    logic [15:0] svc_word;
    logic        svc_req, evnt_ack;
    logic [3:0]  irq_ack;

    int n_pass  = 0;
    int n_total = 0;

    dc_svc #(.SYNC_STAGES(SYNC), .HOLD_CYC(HOLD)) dut (
        .pin_clk  (pin_clk),
        .pin_rst  (pin_rst),
        .irq_in   (irq_in),
        .evnt_in  (evnt_in),
        .halt_in  (halt_in),
        .aclo_n   (aclo_n),
        .dclo_n   (dclo_n),
        .err_n    (err_n),
        .bto      (bto),
        .pri      (pri),
        .svc_rd   (svc_rd),
        .svc_word (svc_word),
        .svc_req  (svc_req),
        .irq_ack  (irq_ack),
        .evnt_ack (evnt_ack)
    );

    always #5 pin_clk = ~pin_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge pin_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    endtask

    // Level L (4..7) lands on word bit 15-L and is shown only while pri < L; the timer
    // event behaves like level 6 on bit 12.
    function automatic logic [15:0] model_word(input logic [3:0] irq, input logic evp,
                                               input logic halt, input logic [2:0] err,
                                               input logic dclo, input int p);
        logic [15:0] w;
        w = 16'h0000;
        for (int lvl = 4; lvl <= 7; lvl++) begin
            if (irq[lvl-4] && p < lvl) w[15-lvl] = 1'b1;
        end
        w[12]  = evp && p < 6;
        w[7]   = 1'b1;
        w[5]   = halt;
        w[4:2] = err;
        w[0]   = dclo;
        return w;
    endfunction

    logic [3:0]  r_irq, e_irq_ack;
    logic [2:0]  r_err, r_pri;
    logic        r_halt, r_dclo, r_ev, m_evp, early, e_req, e_evnt_ack, got;
    logic [15:0] e_w;

    initial begin
        pin_rst = 1'b1; irq_in = 4'b0; evnt_in = 1'b0; halt_in = 1'b0; aclo_n = 1'b1;
        dclo_n = 1'b0; err_n = 3'b111; bto = 1'b0; pri = 3'd7; svc_rd = 1'b0;
        repeat (3) tick();
        check("rst_req", 16'(svc_req), 16'd0);
        check("rst_irq_ack", 16'(irq_ack), 16'd0);
        check("rst_evnt_ack", 16'(evnt_ack), 16'd0);
        check("rst_word", svc_word, 16'o000234);
        pin_rst = 1'b0;
        tick();
        check("post_rst_word", svc_word, 16'o000234);
        check("post_rst_req", 16'(svc_req), 16'd0);

        // IRQ6 at pri 3
        pri = 3'd3; irq_in = 4'b0100;
        repeat (SYNC) tick();
        check("irq6_live", svc_word, 16'o001234);
        check("irq6_not_yet", 16'(svc_req), 16'd0);
        tick();
        check("irq6_req", 16'(svc_req), 16'd1);
        check("irq6_word", svc_word, 16'o001234);
        svc_rd = 1'b1; irq_in = 4'b0;
        tick();
        svc_rd = 1'b0;
        check("irq6_ack", 16'(irq_ack), 16'b0100);
        check("irq6_ack_req", 16'(svc_req), 16'd0);
        for (int i = 0; i < int'(HOLD); i++) begin
            tick();
            check("irq6_hold_req", 16'(svc_req), 16'd0);
            check("irq6_hold_ack", 16'(irq_ack), 16'd0);
        end
        repeat (SYNC + 2) tick();

        // IRQ5+IRQ4 masked, then unmasked
        pri = 3'd6; irq_in = 4'b0011;
        repeat (SYNC + 3) tick();
        check("irq54_masked_req", 16'(svc_req), 16'd0);
        check("irq54_masked_word", svc_word, 16'o000234);
        pri = 3'd3;
        #1;
        check("irq54_live", svc_word, 16'o006234);
        tick();
        check("irq54_req", 16'(svc_req), 16'd1);
        pri = 3'd7;
        #1;
        check("irq54_frozen", svc_word, 16'o006234);
        svc_rd = 1'b1; irq_in = 4'b0;
        tick();
        svc_rd = 1'b0;
        check("irq54_ack", 16'(irq_ack), 16'b0010);
        repeat (HOLD + SYNC + 3) tick();

        // Timer event held while masked
        evnt_in = 1'b1;
        repeat (SYNC + 1) tick();
        evnt_in = 1'b0;
        repeat (SYNC + 2) tick();
        check("evnt_held_req", 16'(svc_req), 16'd0);
        pri = 3'd0;
        #1;
        check("evnt_live", svc_word, 16'o010234);
        tick();
        check("evnt_req", 16'(svc_req), 16'd1);
        svc_rd = 1'b1;
        tick();
        svc_rd = 1'b0;
        check("evnt_ack", 16'(evnt_ack), 16'd1);
        check("evnt_no_irq_ack", 16'(irq_ack), 16'd0);
        tick();
        check("evnt_ack_one_cycle", 16'(evnt_ack), 16'd0);
        repeat (HOLD + 3) tick();
        check("evnt_cleared_req", 16'(svc_req), 16'd0);
        check("evnt_cleared_word", svc_word, 16'o000234);

        // Power-down edge during cool-down
        irq_in = 4'b1000;
        repeat (SYNC + 1) tick();
        check("irq7_req", 16'(svc_req), 16'd1);
        check("irq7_word", svc_word, 16'o000634);
        svc_rd = 1'b1; irq_in = 4'b0;
        tick();
        svc_rd = 1'b0;
        check("irq7_ack", 16'(irq_ack), 16'b1000);
        aclo_n = 1'b0;
        tick();
        check("aclo_hold_req", 16'(svc_req), 16'd0);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (svc_req) got = 1'b1;
        end
        check("aclo_req", 16'(svc_req), 16'd1);
        check("aclo_word", svc_word, 16'o000034);
        svc_rd = 1'b1;
        tick();
        svc_rd = 1'b0;
        check("aclo_no_irq_ack", 16'(irq_ack), 16'd0);
        check("aclo_no_evnt_ack", 16'(evnt_ack), 16'd0);
        repeat (HOLD + 3) tick();
        check("aclo_cleared_req", 16'(svc_req), 16'd0);
        check("aclo_cleared_word", svc_word, 16'o000234);
        aclo_n = 1'b1;
        repeat (SYNC + 2) tick();

        // Reset while pending aborts the acknowledge
        irq_in = 4'b1000;
        repeat (SYNC + 1) tick();
        check("rstpend_req", 16'(svc_req), 16'd1);
        pin_rst = 1'b1; svc_rd = 1'b1;
        tick();
        check("rstpend_req_drop", 16'(svc_req), 16'd0);
        check("rstpend_no_ack", 16'(irq_ack), 16'd0);
        pin_rst = 1'b0; svc_rd = 1'b0;
        for (int i = 0; i < int'(SYNC); i++) begin
            tick();
            check("rstpend_quiet_ack", 16'(irq_ack), 16'd0);
        end
        check("rstpend_quiet_req", 16'(svc_req), 16'd0);
        tick();
        check("rstpend_reraise", 16'(svc_req), 16'd1);
        svc_rd = 1'b1; irq_in = 4'b0;
        tick();
        svc_rd = 1'b0;
        check("rstpend_ack", 16'(irq_ack), 16'b1000);
        repeat (HOLD + SYNC + 3) tick();

        // Bus timeout
        bto = 1'b1;
        tick();
        bto = 1'b0;
        tick();
        check("bto_req", 16'(svc_req), 16'd1);
        check("bto_word", svc_word, 16'o000236);
        svc_rd = 1'b1;
        tick();
        svc_rd = 1'b0;
        check("bto_no_ack", 16'({irq_ack, evnt_ack}), 16'd0);
        repeat (HOLD + 3) tick();
        check("bto_cleared_word", svc_word, 16'o000234);
        check("bto_cleared_req", 16'(svc_req), 16'd0);

        // Randomized transactions
        pri = 3'd7;
        m_evp = 1'b0;
        for (int t = 0; t < 24; t++) begin
            r_irq  = 4'($urandom_range(0, 15));
            r_halt = ($urandom_range(0, 3) == 0);
            r_err  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            r_dclo = 1'($urandom_range(0, 1));
            r_ev   = ($urandom_range(0, 2) == 0);
            r_pri  = 3'($urandom_range(0, 7));
            pri = 3'd7; irq_in = r_irq; halt_in = r_halt; err_n = r_err;
            dclo_n = r_dclo; evnt_in = r_ev;
            repeat (SYNC + 3) tick();
            evnt_in = 1'b0;
            if (r_ev) m_evp = 1'b1;
            early = r_halt || (r_err != 3'b111);
            if (early) begin
                e_w = model_word(r_irq, m_evp, r_halt, r_err, r_dclo, 7);
            end else begin
                check("rnd_masked_req", 16'(svc_req), 16'd0);
                pri = r_pri;
                tick();
                e_w = model_word(r_irq, m_evp, r_halt, r_err, r_dclo, int'(r_pri));
            end
            e_req = (|e_w[12:8]) || r_halt || (r_err != 3'b111);
            check("rnd_req", 16'(svc_req), 16'(e_req));
            check("rnd_word", svc_word, e_w);
            if (e_req) begin
                pri = 3'($urandom_range(0, 7));
                #1;
                check("rnd_frozen", svc_word, e_w);
                e_irq_ack = 4'b0;
                e_evnt_ack = 1'b0;
                for (int lvl = 7; lvl >= 4; lvl--) begin
                    if (e_irq_ack == 4'b0 && e_w[15-lvl]) e_irq_ack[lvl-4] = 1'b1;
                end
                if (e_irq_ack == 4'b0 && e_w[12]) e_evnt_ack = 1'b1;
                svc_rd = 1'b1;
            end
            irq_in = 4'b0; halt_in = 1'b0; err_n = 3'b111; dclo_n = 1'b0;
            if (e_req) begin
                tick();
                svc_rd = 1'b0;
                check("rnd_irq_ack", 16'(irq_ack), 16'(e_irq_ack));
                check("rnd_evnt_ack", 16'(evnt_ack), 16'(e_evnt_ack));
                if (e_evnt_ack) m_evp = 1'b0;
            end
            pri = 3'd7;
            repeat (HOLD + SYNC + 4) tick();
            check("rnd_quiet_req", 16'(svc_req), 16'd0);
            check("rnd_quiet_word", svc_word, 16'o000234);
        end

        // Whatever event is still pending must surface once unmasked
        pri = 3'd0;
        #1;
        check("rnd_evp_final", svc_word, m_evp ? 16'o010234 : 16'o000234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
